phy_regfile_read_stage: RTL and testbench

Parametrised register-read stage between rename and the reservation stations. It holds the physical register file with `NUM_CDB` write-back ports and buffers renamed instructions in a `BUF_DEPTH`-entry skid FIFO, replacing the single stalled slot. Operands are read when an instruction leaves the FIFO, with optional same-cycle CDB forwarding. Results are registered toward issue under a valid/ready handshake.

---
 rtl/phy_regfile_read_stage.sv | 204 ++++++++++++++++++++
 tb/tb_phy_regfile_read_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_regfile_read_stage.sv
// phy_regfile_read_stage: physical register file with NUM_CDB write-back
// ports, a BUF_DEPTH-entry skid FIFO of renamed instructions, and a
// registered valid/ready output toward the reservation stations.
// Optional feature macro: PHY_REGFILE_CDB_BYPASS_EN (same-cycle CDB
// forwarding into operands captured on pop).

`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 6
`endif
`ifndef NOP_CONTROL
`define NOP_CONTROL phy_regfile_read_stage_pkg::NOP_CONTROL_VAL
`endif

package phy_regfile_read_stage_pkg;
    typedef enum logic {src_reg2 = 1'b0, src_imm = 1'b1} alu_src_t;
    typedef enum logic [2:0] {
        add_op = 3'd0, sub_op = 3'd1, and_op = 3'd2, or_op = 3'd3,
        xor_op = 3'd4, sll_op = 3'd5, srl_op = 3'd6, slt_op = 3'd7
    } alu_op_t;
    typedef enum logic [1:0] {no_mem_op = 2'd0, load_op = 2'd1, store_op = 2'd2} mem_op_t;

    typedef struct packed {
        alu_src_t alu_src;
        alu_op_t  alu_op;
        logic     is_branch_op;
        mem_op_t  memory_op;
        logic     reg_wb;
    } control_t;

    localparam control_t NOP_CONTROL_VAL = '{
        alu_src: src_reg2, alu_op: add_op, is_branch_op: 1'b0,
        memory_op: no_mem_op, reg_wb: 1'b0
    };
endpackage

module phy_regfile_read_stage
    import phy_regfile_read_stage_pkg::*;
#(
    parameter int PHY_REG_NUM = 64,
    parameter int REG_W       = `REG_VAL_WIDTH,
    parameter int IMM_W       = `REG_VAL_WIDTH,
    parameter int NUM_CDB     = 2,
    parameter int BUF_DEPTH   = 2,
    localparam int PRW        = $clog2(PHY_REG_NUM),
    localparam int CW         = $clog2(BUF_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PRW-1:0]                src_phy_reg1_in,
    input  logic [PRW-1:0]                src_phy_reg2_in,
    input  logic [PRW-1:0]                dst_phy_reg_in,
    input  control_t                      control_in,
    input  logic [`INST_ADDR_WIDTH-1:0]   pc_in,
    input  logic [IMM_W-1:0]              generated_immediate_in,
    input  logic [`ROB_SIZE_WIDTH-1:0]    inst_tag_in,
    input  logic [NUM_CDB-1:0]            cdb_valid,
    input  logic [NUM_CDB*PRW-1:0]        cdb_reg_addr,
    input  logic [NUM_CDB*REG_W-1:0]      cdb_reg_val,
    input  logic                          flush,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [REG_W-1:0]              src_val1,
    output logic [REG_W-1:0]              src_val2,
    output logic [PRW-1:0]                src_phy_reg1_out,
    output logic [PRW-1:0]                src_phy_reg2_out,
    output logic [PRW-1:0]                dst_phy_reg_out,
    output control_t                      control_out,
    output logic [`INST_ADDR_WIDTH-1:0]   pc_out,
    output logic [IMM_W-1:0]              generated_immediate_out,
    output logic [`ROB_SIZE_WIDTH-1:0]    inst_tag_out,
    output logic [CW-1:0]                 buf_count
);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    typedef struct packed {
        logic [PRW-1:0]              src1;
        logic [PRW-1:0]              src2;
        logic [PRW-1:0]              dst;
        control_t                    control;
        logic [`INST_ADDR_WIDTH-1:0] pc;
        logic [IMM_W-1:0]            imm;
        logic [`ROB_SIZE_WIDTH-1:0]  tag;
    } entry_t;

    logic [REG_W-1:0] rf [PHY_REG_NUM];
    entry_t           fifo_mem [BUF_DEPTH];
    entry_t           entry_in;
    entry_t           head;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             adv;
    logic             push;
    logic             pop;
    logic [REG_W-1:0] op_val1;
    logic [REG_W-1:0] op_val2;

    // Pointers wrap at BUF_DEPTH so non-power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // in_ready looks only at registered occupancy, never at out_ready.
    assign in_ready = (buf_count < CW'(BUF_DEPTH));
    assign adv      = out_ready || !out_valid;
    assign push     = in_valid && in_ready && !flush;
    assign pop      = adv && (buf_count != '0) && !flush;

    assign entry_in = '{
        src1: src_phy_reg1_in, src2: src_phy_reg2_in, dst: dst_phy_reg_in,
        control: control_in, pc: pc_in, imm: generated_immediate_in,
        tag: inst_tag_in
    };

    // Regfile write-back; descending loop lets the lowest CDB port win.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHY_REG_NUM; i++) rf[i] <= '0;
        end else begin
            for (int k = NUM_CDB - 1; k >= 0; k--) begin
                if (cdb_valid[k] && cdb_reg_addr[k*PRW +: PRW] != '0)
                    rf[cdb_reg_addr[k*PRW +: PRW]] <= cdb_reg_val[k*REG_W +: REG_W];
            end
        end
    end

    // FIFO payload storage; contents are only meaningful below buf_count.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= entry_in;
    end

    // FIFO pointers and occupancy; flush empties and drops any push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_count <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_count <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      buf_count <= buf_count + CW'(1);
            else if (pop && !push) buf_count <= buf_count - CW'(1);
        end
    end

    // Operand read for the FIFO head, with optional same-cycle CDB forward.
    always_comb begin
        head    = fifo_mem[rd_ptr];
        op_val1 = (head.src1 == '0) ? '0 : rf[head.src1];
        op_val2 = (head.src2 == '0) ? '0 : rf[head.src2];
`ifdef PHY_REGFILE_CDB_BYPASS_EN
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && head.src1 != '0 && cdb_reg_addr[k*PRW +: PRW] == head.src1)
                op_val1 = cdb_reg_val[k*REG_W +: REG_W];
            if (cdb_valid[k] && head.src2 != '0 && cdb_reg_addr[k*PRW +: PRW] == head.src2)
                op_val2 = cdb_reg_val[k*REG_W +: REG_W];
        end
`endif
    end

    // Output register: loads on pop, holds while stalled, cleared by flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid               <= 1'b0;
            src_val1                <= '0;
            src_val2                <= '0;
            src_phy_reg1_out        <= '0;
            src_phy_reg2_out        <= '0;
            dst_phy_reg_out         <= '0;
            control_out             <= `NOP_CONTROL;
            pc_out                  <= '0;
            generated_immediate_out <= '0;
            inst_tag_out            <= '0;
        end else if (flush) begin
            out_valid   <= 1'b0;
            control_out <= `NOP_CONTROL;
        end else if (pop) begin
            out_valid               <= 1'b1;
            src_val1                <= op_val1;
            src_val2                <= op_val2;
            src_phy_reg1_out        <= head.src1;
            src_phy_reg2_out        <= head.src2;
            dst_phy_reg_out         <= head.dst;
            control_out             <= head.control;
            pc_out                  <= head.pc;
            generated_immediate_out <= head.imm;
            inst_tag_out            <= head.tag;
        end else if (adv) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_phy_regfile_read_stage.sv
// Bench for phy_regfile_read_stage: directed scenarios plus random traffic,
// all checked against a queue/array reference model of the stage.

`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 6
`endif

module tb_phy_regfile_read_stage;
    import phy_regfile_read_stage_pkg::*;

    localparam int PRW   = 6;
    localparam int REG_W = `REG_VAL_WIDTH;
    localparam int NCDB  = 2;
    localparam int DEPTH = 2;
    localparam int TW    = `ROB_SIZE_WIDTH;
    localparam int AW    = `INST_ADDR_WIDTH;

    logic                  clk;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [PRW-1:0]        src_phy_reg1_in, src_phy_reg2_in, dst_phy_reg_in;
    control_t              control_in;
    logic [AW-1:0]         pc_in;
    logic [REG_W-1:0]      generated_immediate_in;
    logic [TW-1:0]         inst_tag_in;
    logic [NCDB-1:0]       cdb_valid;
    logic [NCDB*PRW-1:0]   cdb_reg_addr;
    logic [NCDB*REG_W-1:0] cdb_reg_val;
    logic                  flush;
    logic                  out_ready;
    logic                  out_valid;
    logic [REG_W-1:0]      src_val1, src_val2;
    logic [PRW-1:0]        src_phy_reg1_out, src_phy_reg2_out, dst_phy_reg_out;
    control_t              control_out;
    logic [AW-1:0]         pc_out;
    logic [REG_W-1:0]      generated_immediate_out;
    logic [TW-1:0]         inst_tag_out;
    logic [1:0]            buf_count;

    phy_regfile_read_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .src_phy_reg1_in(src_phy_reg1_in), .src_phy_reg2_in(src_phy_reg2_in),
        .dst_phy_reg_in(dst_phy_reg_in), .control_in(control_in), .pc_in(pc_in),
        .generated_immediate_in(generated_immediate_in), .inst_tag_in(inst_tag_in),
        .cdb_valid(cdb_valid), .cdb_reg_addr(cdb_reg_addr), .cdb_reg_val(cdb_reg_val),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
        .src_val1(src_val1), .src_val2(src_val2),
        .src_phy_reg1_out(src_phy_reg1_out), .src_phy_reg2_out(src_phy_reg2_out),
        .dst_phy_reg_out(dst_phy_reg_out), .control_out(control_out), .pc_out(pc_out),
        .generated_immediate_out(generated_immediate_out), .inst_tag_out(inst_tag_out),
        .buf_count(buf_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [PRW-1:0]   s1, s2, d;
        control_t         ctrl;
        logic [AW-1:0]    pc;
        logic [REG_W-1:0] imm;
        logic [TW-1:0]    tag;
    } instr_t;

    instr_t           q[$];
    instr_t           m_out;
    logic [REG_W-1:0] m_v1, m_v2;
    bit               m_valid;
    bit               m_nop;
    logic [REG_W-1:0] rf_m [64];
    control_t         nop_c;
    int               n_checks = 0;
    int               n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [REG_W-1:0] model_read(input logic [PRW-1:0] a);
        if (a == 0) return '0;
`ifdef PHY_REGFILE_CDB_BYPASS_EN
        for (int k = 0; k < NCDB; k++)
            if (cdb_valid[k] && cdb_reg_addr[k*PRW +: PRW] == a)
                return cdb_reg_val[k*REG_W +: REG_W];
`endif
        return rf_m[a];
    endfunction

    task automatic model_reset();
        q.delete();
        m_valid = 0;
        m_nop   = 1;
        m_out   = '{s1: 0, s2: 0, d: 0, ctrl: nop_c, pc: 0, imm: 0, tag: 0};
        m_v1    = '0;
        m_v2    = '0;
        for (int i = 0; i < 64; i++) rf_m[i] = '0;
    endtask

    // One clock edge of the reference model, using the inputs held across it.
    task automatic model_step();
        int     sz;
        bit     acc;
        instr_t e;
        if (reset === 1'b0) begin
            model_reset();
            return;
        end
        sz  = q.size();
        acc = in_valid && (sz < DEPTH);
        if (flush) begin
            q.delete();
            m_valid = 0;
            m_nop   = 1;
        end else begin
            if (out_ready || !m_valid) begin
                if (sz > 0) begin
                    e       = q.pop_front();
                    m_out   = e;
                    m_v1    = model_read(e.s1);
                    m_v2    = model_read(e.s2);
                    m_valid = 1;
                    m_nop   = 0;
                end else begin
                    m_valid = 0;
                end
            end
            if (acc) begin
                e = '{s1: src_phy_reg1_in, s2: src_phy_reg2_in, d: dst_phy_reg_in,
                      ctrl: control_in, pc: pc_in, imm: generated_immediate_in,
                      tag: inst_tag_in};
                q.push_back(e);
            end
        end
        for (int k = NCDB - 1; k >= 0; k--)
            if (cdb_valid[k] && cdb_reg_addr[k*PRW +: PRW] != 0)
                rf_m[cdb_reg_addr[k*PRW +: PRW]] = cdb_reg_val[k*REG_W +: REG_W];
    endtask

    task automatic compare_all();
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("buf_count", 64'(buf_count), 64'(q.size()));
        check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
        if (m_valid) begin
            check("inst_tag_out", 64'(inst_tag_out), 64'(m_out.tag));
            check("pc_out", 64'(pc_out), 64'(m_out.pc));
            check("imm_out", 64'(generated_immediate_out), 64'(m_out.imm));
            check("src1_out", 64'(src_phy_reg1_out), 64'(m_out.s1));
            check("src2_out", 64'(src_phy_reg2_out), 64'(m_out.s2));
            check("dst_out", 64'(dst_phy_reg_out), 64'(m_out.d));
            check("src_val1", 64'(src_val1), 64'(m_v1));
            check("src_val2", 64'(src_val2), 64'(m_v2));
            check("control_out", 64'(control_out), 64'(m_out.ctrl));
        end else if (m_nop) begin
            check("control_nop", 64'(control_out), 64'(nop_c));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drive_instr(input logic [PRW-1:0] s1, input logic [PRW-1:0] s2,
                               input logic [TW-1:0] tag);
        in_valid                 = 1'b1;
        src_phy_reg1_in          = s1;
        src_phy_reg2_in          = s2;
        dst_phy_reg_in           = PRW'($urandom_range(1, 63));
        control_in.alu_src       = alu_src_t'(1'($urandom));
        control_in.alu_op        = alu_op_t'(3'($urandom));
        control_in.is_branch_op  = 1'($urandom);
        control_in.memory_op     = mem_op_t'(2'($urandom_range(0, 2)));
        control_in.reg_wb        = 1'($urandom);
        pc_in                    = AW'($urandom);
        generated_immediate_in   = REG_W'($urandom);
        inst_tag_in              = tag;
    endtask

    task automatic set_cdb(input int k, input logic [PRW-1:0] a, input logic [REG_W-1:0] v);
        cdb_valid[k]                 = 1'b1;
        cdb_reg_addr[k*PRW +: PRW]   = a;
        cdb_reg_val[k*REG_W +: REG_W] = v;
    endtask

    initial begin
        nop_c.alu_src      = src_reg2;
        nop_c.alu_op       = add_op;
        nop_c.is_branch_op = 1'b0;
        nop_c.memory_op    = no_mem_op;
        nop_c.reg_wb       = 1'b0;
        model_reset();

        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        src_phy_reg1_in = '0; src_phy_reg2_in = '0; dst_phy_reg_in = '0;
        control_in = nop_c; pc_in = '0; generated_immediate_in = '0; inst_tag_in = '0;
        cdb_valid = '0; cdb_reg_addr = '0; cdb_reg_val = '0;

        // Reset state
        repeat (3) cycle();
        check("rst_src_val1", 64'(src_val1), 64'h0);
        check("rst_tag", 64'(inst_tag_out), 64'h0);
        check("rst_pc", 64'(pc_out), 64'h0);
        check("rst_dst", 64'(dst_phy_reg_out), 64'h0);
        reset = 1'b1;
        out_ready = 1'b1;
        cycle();

        // CDB read-after-write and r0 hardwired to zero
        set_cdb(1, 6'd5, 32'hA5);
        drive_instr(6'd5, 6'd0, 6'd9);
        cycle();
        cdb_valid = '0;
        in_valid = 1'b0;
        set_cdb(0, 6'd0, 32'hFF);
        cycle();
        cdb_valid = '0;
        check("raw_r5", 64'(src_val1), 64'hA5);
        check("r0_zero", 64'(src_val2), 64'h0);
        cycle();

        // Streaming tags 1..5 with out_ready held high
        for (int t = 1; t <= 5; t++) begin
            drive_instr(PRW'($urandom_range(0, 7)), PRW'($urandom_range(0, 7)), TW'(t));
            cycle();
        end
        in_valid = 1'b0;
        repeat (4) cycle();

        // Backpressure: four pushes against a stalled output
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_instr(6'd1, 6'd2, TW'(10 + i));
            cycle();
        end
        in_valid = 1'b0;
        check("bp_hold_tag", 64'(inst_tag_out), 64'd10);
        check("bp_count", 64'(buf_count), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        cycle();
        check("bp_tag2", 64'(inst_tag_out), 64'd11);
        cycle();
        check("bp_tag3", 64'(inst_tag_out), 64'd12);
        repeat (2) cycle();

        // Same-cycle CDB write to a register being popped
        set_cdb(0, 6'd7, 32'h11);
        cycle();
        cdb_valid = '0;
        drive_instr(6'd3, 6'd7, 6'd20);
        cycle();
        in_valid = 1'b0;
        set_cdb(0, 6'd7, 32'h33);
        set_cdb(1, 6'd7, 32'h44);
        cycle();
        cdb_valid = '0;
`ifdef PHY_REGFILE_CDB_BYPASS_EN
        check("bypass_val2", 64'(src_val2), 64'h33);
`else
        check("bypass_val2", 64'(src_val2), 64'h11);
`endif
        drive_instr(6'd7, 6'd0, 6'd21);
        cycle();
        in_valid = 1'b0;
        cycle();
        check("r7_after", 64'(src_val1), 64'h33);
        cycle();

        // Flush with full FIFO, valid output and a same-cycle push
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_instr(6'd4, 6'd5, TW'(30 + i));
            cycle();
        end
        check("fl_pre_count", 64'(buf_count), 64'd2);
        check("fl_pre_valid", 64'(out_valid), 64'd1);
        drive_instr(6'd4, 6'd5, 6'd33);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_count", 64'(buf_count), 64'd0);
        check("fl_nop", 64'(control_out), 64'(nop_c));
        out_ready = 1'b1;
        repeat (3) cycle();

        // Asynchronous reset with two entries buffered
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_instr(6'd2, 6'd3, TW'(40 + i));
            cycle();
        end
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_count", 64'(buf_count), 64'd0);
        check("ar_nop", 64'(control_out), 64'(nop_c));
        check("ar_in_ready", 64'(in_ready), 64'd1);
        model_reset();
        repeat (2) cycle();
        reset = 1'b1;
        cycle();

        // Random traffic with hazards on a small register window
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 9) < 7)
                drive_instr(PRW'($urandom_range(0, 7)), PRW'($urandom_range(0, 7)), TW'($urandom));
            else
                in_valid = 1'b0;
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 3);
            cdb_valid = '0;
            for (int k = 0; k < NCDB; k++)
                if ($urandom_range(0, 1) == 1)
                    set_cdb(k, PRW'($urandom_range(0, 7)), REG_W'($urandom));
            cycle();
        end
        in_valid = 1'b0; flush = 1'b0; cdb_valid = '0; out_ready = 1'b1;
        repeat (4) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
